// File: rtl/sc_matrix_scanner.sv
// sc_matrix_scanner: MAX7219-class 8x8 matrix refresher (5 init frames, then rows 1-8 forever).
// Define SC_MATRIX_SCANNER_SNAPSHOT_EN to freeze the whole image at the first row frame of each sweep.
module sc_matrix_scanner #(
   parameter int         CLKDIV_HALF = 4,
   parameter logic [3:0] INTENSITY   = 4'h8
) (
   input  logic        SC_MATRIX_SCANNER_CLOCK_50,
   input  logic        SC_MATRIX_SCANNER_RESET_InHigh,
   input  logic        SC_MATRIX_SCANNER_enable_InHigh,
   input  logic [63:0] SC_MATRIX_SCANNER_data_InBUS,
   output logic        SC_MATRIX_SCANNER_din_Out,
   output logic        SC_MATRIX_SCANNER_sclk_Out,
   output logic        SC_MATRIX_SCANNER_load_OutLow,
   output logic        SC_MATRIX_SCANNER_busy_OutHigh,
   output logic        SC_MATRIX_SCANNER_frameDone_OutHigh
);
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LOW, SHIFT_HIGH, LATCH} state_t;
   localparam logic [7:0] PH_LAST = 8'(CLKDIV_HALF - 1);
   state_t      r_state;
   logic [3:0]  r_idx;
   logic [3:0]  r_bit;
   logic [7:0]  r_phase;
   logic [15:0] r_shift;
   logic        r_sclk;
   logic        r_load;
   logic        r_busy;
   logic        r_done;
   logic        w_ph_end;
   logic        w_en;
   logic        w_last_latch;
   logic [3:0]  w_next_idx;
   logic [3:0]  w_sel_idx;
   logic [2:0]  w_row;
   logic [63:0] w_rows;
   logic [7:0]  w_byte;
   logic [15:0] w_frame;

   assign w_en       = SC_MATRIX_SCANNER_enable_InHigh;
   assign w_ph_end   = r_phase == PH_LAST;
   assign w_next_idx = (r_idx == 4'd12) ? 4'd5 : r_idx + 4'd1;
   // The frame loaded when leaving LATCH belongs to the next index
   assign w_sel_idx  = (r_state == LATCH) ? w_next_idx : r_idx;
   assign w_row      = 3'(w_sel_idx - 4'd5);

`ifdef SC_MATRIX_SCANNER_SNAPSHOT_EN
   logic [63:0] r_snap;
   assign w_rows = (w_sel_idx == 4'd5) ? SC_MATRIX_SCANNER_data_InBUS : r_snap;
   always_ff @(posedge SC_MATRIX_SCANNER_CLOCK_50) begin
      if (SC_MATRIX_SCANNER_RESET_InHigh)
         r_snap <= '0;
      else if (w_en && w_sel_idx == 4'd5 && (r_state == IDLE || (r_state == LATCH && w_ph_end)))
         r_snap <= SC_MATRIX_SCANNER_data_InBUS;
   end
`else
   assign w_rows = SC_MATRIX_SCANNER_data_InBUS;
`endif

   assign w_byte  = w_rows[{w_row, 3'b000} +: 8];
   assign w_frame = (w_sel_idx == 4'd0) ? 16'h0F00 :
                    (w_sel_idx == 4'd1) ? 16'h0900 :
                    (w_sel_idx == 4'd2) ? {12'h0A0, INTENSITY} :
                    (w_sel_idx == 4'd3) ? 16'h0B07 :
                    (w_sel_idx == 4'd4) ? 16'h0C01 :
                    {4'h0, w_sel_idx - 4'd4, w_byte};

   // True on the edge that enters the final LATCH cycle
   assign w_last_latch = (CLKDIV_HALF == 1) ?
                         (r_state == SHIFT_HIGH && w_ph_end && r_bit == 4'd15) :
                         (r_state == LATCH && r_phase == PH_LAST - 8'd1);

   always_ff @(posedge SC_MATRIX_SCANNER_CLOCK_50) begin
      if (SC_MATRIX_SCANNER_RESET_InHigh) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_bit   <= '0;
         r_phase <= '0;
         r_shift <= '0;
         r_sclk  <= 1'b0;
         r_load  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last_latch && r_idx == 4'd12;
         case (r_state)
            IDLE:
               if (w_en) begin
                  r_state <= LOAD;
                  r_shift <= w_frame;
                  r_load  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            LOAD: begin
               r_state <= SHIFT_LOW;
               r_phase <= '0;
               r_bit   <= '0;
            end
            SHIFT_LOW:
               if (w_ph_end) begin
                  r_state <= SHIFT_HIGH;
                  r_sclk  <= 1'b1;
                  r_phase <= '0;
               end else
                  r_phase <= r_phase + 8'd1;
            SHIFT_HIGH:
               if (w_ph_end) begin
                  // The 16th shift leaves the register all-zero, which is the idle din level
                  r_sclk  <= 1'b0;
                  r_phase <= '0;
                  r_shift <= {r_shift[14:0], 1'b0};
                  r_bit   <= r_bit + 4'd1;
                  r_state <= (r_bit == 4'd15) ? LATCH : SHIFT_LOW;
                  r_load  <= r_bit == 4'd15;
               end else
                  r_phase <= r_phase + 8'd1;
            LATCH:
               if (w_ph_end) begin
                  r_idx   <= w_next_idx;
                  r_phase <= '0;
                  if (w_en) begin
                     r_state <= LOAD;
                     r_shift <= w_frame;
                     r_load  <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else
                  r_phase <= r_phase + 8'd1;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign SC_MATRIX_SCANNER_din_Out           = r_shift[15];
   assign SC_MATRIX_SCANNER_sclk_Out          = r_sclk;
   assign SC_MATRIX_SCANNER_load_OutLow       = r_load;
   assign SC_MATRIX_SCANNER_busy_OutHigh      = r_busy;
   assign SC_MATRIX_SCANNER_frameDone_OutHigh = r_done;
endmodule

// File: tb/tb_sc_matrix_scanner.sv
// tb_sc_matrix_scanner: decodes the serial stream of a default and a CLKDIV_HALF=1 instance
module tb_sc_matrix_scanner;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [63:0] data = '0;
   logic        din, sclk, load, busy, done;
   logic        din2, sclk2, load2, busy2, done2;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] q[$];
   logic [15:0] init_f [5] = '{16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01};
   logic [15:0] row_f  [8] = '{16'h0101, 16'h0202, 16'h0304, 16'h0408,
                               16'h0510, 16'h0620, 16'h0740, 16'h0880};

   always #5 clk = ~clk;

   sc_matrix_scanner dut (
      .SC_MATRIX_SCANNER_CLOCK_50          (clk),
      .SC_MATRIX_SCANNER_RESET_InHigh      (rst),
      .SC_MATRIX_SCANNER_enable_InHigh     (en),
      .SC_MATRIX_SCANNER_data_InBUS        (data),
      .SC_MATRIX_SCANNER_din_Out           (din),
      .SC_MATRIX_SCANNER_sclk_Out          (sclk),
      .SC_MATRIX_SCANNER_load_OutLow       (load),
      .SC_MATRIX_SCANNER_busy_OutHigh      (busy),
      .SC_MATRIX_SCANNER_frameDone_OutHigh (done)
   );

   sc_matrix_scanner #(.CLKDIV_HALF(1)) dut2 (
      .SC_MATRIX_SCANNER_CLOCK_50          (clk),
      .SC_MATRIX_SCANNER_RESET_InHigh      (rst),
      .SC_MATRIX_SCANNER_enable_InHigh     (en),
      .SC_MATRIX_SCANNER_data_InBUS        (data),
      .SC_MATRIX_SCANNER_din_Out           (din2),
      .SC_MATRIX_SCANNER_sclk_Out          (sclk2),
      .SC_MATRIX_SCANNER_load_OutLow       (load2),
      .SC_MATRIX_SCANNER_busy_OutHigh      (busy2),
      .SC_MATRIX_SCANNER_frameDone_OutHigh (done2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_q(input int n);
      int k = 0;
      while (q.size() < n && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk("frames_seen", 64'(q.size()), 64'(n));
   endtask

   // Stream decoder for the default instance: only complete 16-bit frames are queued
   int          cyc = 0, t_fall = 0, n_falls = 0, period = 0, lowc = 0, first_low = 0;
   int          dec_bits = 0, done_cnt = 0;
   logic [15:0] w = '0;
   logic        p_load = 1'b1, p_sclk = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (p_load && !load) begin
         if (n_falls == 1) period = cyc - t_fall;
         t_fall = cyc;
         n_falls++;
         dec_bits = 0;
         w = '0;
         lowc = 0;
      end
      if (!load) lowc++;
      if (!load && sclk && !p_sclk) begin
         w = {w[14:0], din};
         dec_bits++;
      end
      if (!p_load && load && dec_bits == 16) begin
         q.push_back(w);
         if (first_low == 0) first_low = lowc;
      end
      if (done) done_cnt++;
      p_load = load;
      p_sclk = sclk;
   end

   // Decoder for the CLKDIV_HALF=1 instance: first-frame timing and din stability
   int          cyc2 = 0, t2 = 0, falls2 = 0, period2 = 0, rise2 = 0, hi2 = 0;
   int          rises2_f = 0, hi2_f = 0, viol2 = 0;
   logic [15:0] w2 = '0, word2 = '0;
   logic        got2 = 1'b0, p_load2 = 1'b1, p_sclk2 = 1'b0, p_din2 = 1'b0;
   always @(negedge clk) begin
      cyc2++;
      if (p_load2 && !load2) begin
         if (falls2 == 1) period2 = cyc2 - t2;
         t2 = cyc2;
         falls2++;
         w2 = '0;
         rise2 = 0;
         hi2 = 0;
      end
      if (!load2 && sclk2) hi2++;
      if (!load2 && sclk2 && !p_sclk2) begin
         w2 = {w2[14:0], din2};
         rise2++;
      end
      if (!p_load2 && load2 && !got2 && falls2 > 0) begin
         got2 = 1'b1;
         word2 = w2;
         rises2_f = rise2;
         hi2_f = hi2;
      end
      if (din2 != p_din2 && sclk2) viol2++;
      p_load2 = load2;
      p_sclk2 = sclk2;
      p_din2 = din2;
   end

   initial begin
      int k;
      logic [7:0] b;
      repeat (3) @(negedge clk);
      chk("rst_din", 64'(din), 0);
      chk("rst_sclk", 64'(sclk), 0);
      chk("rst_load", 64'(load), 1);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      data = 64'h8040201008040201;
      rst = 1'b0;
      en = 1'b1;
      wait_q(14);
      for (int i = 0; i < 5; i++) chk($sformatf("init%0d", i), 64'(q[i]), 64'(init_f[i]));
      for (int r = 0; r < 8; r++) chk($sformatf("row%0d", r), 64'(q[5 + r]), 64'(row_f[r]));
      chk("wrap", 64'(q[13]), 64'h0101);
      chk("period", 64'(period), 133);
      chk("load_low", 64'(first_low), 129);
      chk("done_once", 64'(done_cnt), 1);
      chk("busy_latch", 64'(busy), 1);
      chk("h1_period", 64'(period2), 34);
      chk("h1_word", 64'(word2), 64'h0F00);
      chk("h1_rises", 64'(rises2_f), 16);
      chk("h1_high", 64'(hi2_f), 16);
      chk("h1_din_stable", 64'(viol2), 0);
      k = 0;
      while (!(q.size() >= 15 && !load && dec_bits == 6) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("bit6_reached", 64'(dec_bits), 6);
      en = 1'b0;
      wait_q(16);
      chk("frame7_done", 64'(q[15]), 64'h0304);
      repeat (8) @(negedge clk);
      chk("idle_load", 64'(load), 1);
      chk("idle_busy", 64'(busy), 0);
      chk("idle_sclk", 64'(sclk), 0);
      chk("idle_din", 64'(din), 0);
      repeat (40) @(negedge clk);
      chk("no_restart", 64'(q.size()), 16);
      en = 1'b1;
      wait_q(17);
      chk("resume8", 64'(q[16]), 64'h0408);
      chk("done_still_once", 64'(done_cnt), 1);
      k = 0;
      while (!(q.size() >= 17 && !load && sclk) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("in_shift_high", 64'(sclk), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_load", 64'(load), 1);
      chk("abort_sclk", 64'(sclk), 0);
      chk("abort_din", 64'(din), 0);
      chk("abort_busy", 64'(busy), 0);
      rst = 1'b0;
      wait_q(18);
      chk("restart0", 64'(q[17]), 64'h0F00);
      data = '0;
      wait_q(25);
      data = '1;
      wait_q(31);
      for (int r = 0; r < 8; r++) begin
`ifdef SC_MATRIX_SCANNER_SNAPSHOT_EN
         b = 8'h00;
`else
         b = (r >= 3) ? 8'hFF : 8'h00;
`endif
         chk($sformatf("sweep_row%0d", r), 64'(q[22 + r]), 64'({4'h0, 4'(r + 1), b}));
      end
      chk("next_sweep", 64'(q[30]), 64'h01FF);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
